// File: rtl/led_pkg.sv
// Shared mode encodings and pattern start values for the LED controller.
package led_pkg;

  localparam int unsigned LED_W  = 8;
  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_DIRECT = 2'd0,
    MODE_FLOW   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  localparam logic [LED_W-1:0] PAT_ONEHOT = 8'h01;
  localparam logic [LED_W-1:0] PAT_ALL    = 8'hFF;

  // Pattern value loaded on entry to a mode (DIRECT does not display it).
  function automatic logic [LED_W-1:0] mode_start(input mode_e m);
    return (m == MODE_BLINK) ? PAT_ALL : PAT_ONEHOT;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Active-low button conditioner: 2-flop synchroniser, stability counter, press pulse.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 240_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_n,
  output logic o_press
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  // Synchronise, count consecutive cycles of disagreement, accept level at terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_press <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED source scheduler: mode FSM stepped by a debounced button, prescaled pattern engine.
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 3_000_000,
  parameter int unsigned DEB_CYCLES = 240_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        key,
  input  logic [3:0]        sw,
  input  logic              mode_btn,
  output logic [LED_W-1:0]  led,
  output logic [MODE_W-1:0] mode
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  mode_e             r_mode;
  mode_e             w_mode_nxt;
  logic [LED_W-1:0]  r_pattern;
  logic [LED_W-1:0]  w_pattern_nxt;
  logic [LED_W-1:0]  r_led;
  logic [LED_W-1:0]  w_led_nxt;
  logic              r_dir_right;
  logic              w_dir_right_nxt;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [TICK_W-1:0] w_tick_cnt_nxt;
  logic              w_press;
  logic              w_run;
  logic              w_tick;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_mode_btn (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn_n(mode_btn),
    .o_press(w_press)
  );

  assign w_run  = (r_mode != MODE_DIRECT) && !sw[0];
  assign w_tick = w_run && (r_tick_cnt == TICK_W'(TICK_DIV - 1));

  // State register for mode, pattern engine and LED drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode      <= MODE_DIRECT;
      r_pattern   <= PAT_ONEHOT;
      r_dir_right <= 1'b0;
      r_tick_cnt  <= '0;
      r_led       <= '0;
    end else begin
      r_mode      <= w_mode_nxt;
      r_pattern   <= w_pattern_nxt;
      r_dir_right <= w_dir_right_nxt;
      r_tick_cnt  <= w_tick_cnt_nxt;
      r_led       <= w_led_nxt;
    end
  end

  // Next state: a press overrides a coincident tick and reloads the entered mode.
  always_comb begin
    w_mode_nxt      = r_mode;
    w_pattern_nxt   = r_pattern;
    w_dir_right_nxt = r_dir_right;
    w_tick_cnt_nxt  = r_tick_cnt;
    w_led_nxt       = (r_mode == MODE_DIRECT) ? {key, sw} : r_pattern;

    if (w_press) begin
      w_mode_nxt      = mode_e'(MODE_W'(r_mode + 2'd1));
      w_pattern_nxt   = mode_start(w_mode_nxt);
      w_dir_right_nxt = 1'b0;
      w_tick_cnt_nxt  = '0;
    end else if (r_mode == MODE_DIRECT) begin
      w_tick_cnt_nxt = '0;
    end else if (w_run) begin
      w_tick_cnt_nxt = w_tick ? '0 : r_tick_cnt + TICK_W'(1);
      if (w_tick) begin
        case (r_mode)
          MODE_FLOW: begin
            w_pattern_nxt = {r_pattern[LED_W-2:0], r_pattern[LED_W-1]};
          end
          MODE_BOUNCE: begin
            if (!r_dir_right) begin
              if (r_pattern[LED_W-1]) begin
                w_pattern_nxt   = r_pattern >> 1;
                w_dir_right_nxt = 1'b1;
              end else begin
                w_pattern_nxt = r_pattern << 1;
              end
            end else begin
              if (r_pattern[0]) begin
                w_pattern_nxt   = r_pattern << 1;
                w_dir_right_nxt = 1'b0;
              end else begin
                w_pattern_nxt = r_pattern >> 1;
              end
            end
          end
          MODE_BLINK: begin
            w_pattern_nxt = ~r_pattern;
          end
          default: begin
            w_pattern_nxt = r_pattern;
          end
        endcase
      end
    end
  end

  assign led  = r_led;
  assign mode = MODE_W'(r_mode);

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl: each expected {led,mode} change is queued with its timing.
module tb_led_pattern_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key;
  logic [3:0] sw;
  logic       mode_btn;
  logic [7:0] led;
  logic [1:0] mode;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    string      name;
    logic [7:0] led;
    logic [1:0] mode;
    int         at;
    int         dt;
  } exp_t;

  exp_t q[$];

  led_pattern_ctrl #(
    .TICK_DIV  (4),
    .DEB_CYCLES(3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key     (key),
    .sw      (sw),
    .mode_btn(mode_btn),
    .led     (led),
    .mode    (mode)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input string nm, input logic [7:0] l, input logic [1:0] m,
                      input int at, input int dt);
    exp_t e;
    e.name = nm;
    e.led  = l;
    e.mode = m;
    e.at   = at;
    e.dt   = dt;
    q.push_back(e);
  endtask

  task automatic check_eq(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    check_eq({nm, "_pending"}, q.size(), 0);
  endtask

  // Press and hold for 'hold' cycles; mode changes 6 edges after the fall.
  task automatic do_press(input string nm, input logic [7:0] led_m, input logic [1:0] m,
                          input bit second, input logic [7:0] led2, input int hold);
    int t0;
    t0 = cyc;
    push({nm, "_mode"}, led_m, m, t0 + 6, -1);
    if (second) push({nm, "_led"}, led2, m, t0 + 7, -1);
    mode_btn = 1'b0;
    repeat (hold) @(negedge clk);
    mode_btn = 1'b1;
    repeat (15) @(negedge clk);
  endtask

  // Monitor: every change of {led,mode} must match the head of the queue.
  initial begin : monitor
    logic [9:0] prev;
    int         last;
    exp_t       e;
    bit         ok;
    @(posedge rst_n);
    prev = {led, mode};
    last = cyc;
    forever begin
      @(negedge clk);
      if ({led, mode} !== prev) begin
        prev = {led, mode};
        n_checks++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_change: got led=%02h mode=%0d at cyc=%0d, expected no change",
                   led, mode, cyc);
        end else begin
          e  = q.pop_front();
          ok = (led === e.led) && (mode === e.mode) &&
               (e.at < 0 || cyc == e.at) && (e.dt < 0 || (cyc - last) == e.dt);
          if (ok) n_pass++;
          else $display("FAIL %s: got led=%02h mode=%0d cyc=%0d dt=%0d, expected led=%02h mode=%0d at=%0d dt=%0d",
                        e.name, led, mode, cyc, cyc - last, e.led, e.mode, e.at, e.dt);
        end
        last = cyc;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    int t0;
    int t1;
    int t2;
    int t3;
    logic [7:0] v;
    logic [7:0] bseq [14];

    rst_n    = 1'b1;
    key      = 4'h0;
    sw       = 4'h0;
    mode_btn = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_led", led, 8'h00);
    check_eq("reset_mode", mode, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // DIRECT display with one-cycle latency
    t0 = cyc;
    push("direct_a5", 8'hA5, 2'd0, t0 + 1, -1);
    key = 4'hA; sw = 4'h5;
    repeat (3) @(negedge clk);
    t0 = cyc;
    push("direct_3c", 8'h3C, 2'd0, t0 + 1, -1);
    key = 4'h3; sw = 4'hC;
    repeat (3) @(negedge clk);
    drain("direct");

    // Asynchronous reset mid-run
    push("midrst", 8'h00, 2'd0, -1, -1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_led_now", led, 8'h00);
    check_eq("midrst_mode_now", mode, 0);
    repeat (3) @(negedge clk);
    key = 4'h0; sw = 4'h0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    drain("midrst");

    // Clean press into FLOW, full rotation
    t0 = cyc;
    push("p1_mode", 8'h00, 2'd1, t0 + 6, -1);
    push("flow_01", 8'h01, 2'd1, t0 + 7, -1);
    v = 8'h02;
    for (int i = 0; i < 8; i++) begin
      push("flow_step", v, 2'd1, -1, 4);
      v = {v[6:0], v[7]};
    end
    mode_btn = 1'b0;
    repeat (10) @(negedge clk);
    mode_btn = 1'b1;
    wait_cyc(t0 + 40);
    sw = 4'h1;
    drain("flow");

    // Bounces shorter than the debounce window are ignored
    mode_btn = 1'b0;
    repeat (2) @(negedge clk);
    mode_btn = 1'b1;
    @(negedge clk);
    mode_btn = 1'b0;
    repeat (2) @(negedge clk);
    mode_btn = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("glitch_mode", mode, 1);

    // Long hold gives a single advance
    do_press("hold", 8'h01, 2'd2, 1'b0, 8'h00, 20);
    drain("hold");

    // BOUNCE sweep
    bseq = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
             8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    t1 = cyc;
    push("bnc_02", 8'h02, 2'd2, t1 + 5, -1);
    for (int i = 0; i < 14; i++) push("bnc_step", bseq[i], 2'd2, -1, 4);
    sw = 4'h0;
    wait_cyc(t1 + 61);
    sw = 4'h1;
    drain("bounce");

    // Re-press into BLINK; pause mid-count and resume with count preserved
    do_press("blink", 8'h02, 2'd3, 1'b1, 8'hFF, 10);
    drain("blink_enter");
    check_eq("blink_start_led", led, 8'hFF);
    t2 = cyc;
    sw = 4'h0;
    wait_cyc(t2 + 2);
    sw = 4'h1;
    wait_cyc(t2 + 14);
    check_eq("frozen_led", led, 8'hFF);
    check_eq("frozen_mode", mode, 3);
    push("blink_resume", 8'h00, 2'd3, t2 + 17, -1);
    push("blink_ff", 8'hFF, 2'd3, -1, 4);
    push("blink_00", 8'h00, 2'd3, -1, 4);
    sw = 4'h0;
    wait_cyc(t2 + 25);
    sw = 4'h1;
    drain("blink");

    // Back to FLOW via DIRECT, then press exactly on the tick at 8'h08
    do_press("to_direct", 8'h00, 2'd0, 1'b1, 8'h01, 10);
    do_press("to_flow", 8'h01, 2'd1, 1'b0, 8'h00, 10);
    drain("to_flow");
    t3 = cyc;
    push("ft_02", 8'h02, 2'd1, t3 + 5, -1);
    push("ft_04", 8'h04, 2'd1, -1, 4);
    push("ft_08", 8'h08, 2'd1, -1, 4);
    push("ft_press_mode", 8'h08, 2'd2, t3 + 16, -1);
    push("ft_press_led", 8'h01, 2'd2, t3 + 17, -1);
    sw = 4'h0;
    wait_cyc(t3 + 10);
    mode_btn = 1'b0;
    wait_cyc(t3 + 17);
    sw = 4'h1;
    wait_cyc(t3 + 20);
    mode_btn = 1'b1;
    repeat (15) @(negedge clk);
    drain("press_on_tick");

    // Into BLINK, then four presses wrap back to BLINK
    do_press("to_blink", 8'h01, 2'd3, 1'b1, 8'hFF, 10);
    do_press("wrap0", 8'hFF, 2'd0, 1'b1, 8'h01, 10);
    do_press("wrap1", 8'h01, 2'd1, 1'b0, 8'h00, 10);
    do_press("wrap2", 8'h01, 2'd2, 1'b0, 8'h00, 10);
    do_press("wrap3", 8'h01, 2'd3, 1'b1, 8'hFF, 10);
    drain("wrap");
    check_eq("final_mode", mode, 3);

    repeat (20) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
